// File: rtl/k005292_timing_pkg.sv
// Default geometry and span-decode helper shared by the k005292 timing generator.
package k005292_timing_pkg;

    localparam int unsigned DEF_HW          = 9;
    localparam int unsigned DEF_VW          = 9;
    localparam int unsigned DEF_H_FIRST     = 128;
    localparam int unsigned DEF_H_LAST      = 511;
    localparam int unsigned DEF_V_FIRST     = 248;
    localparam int unsigned DEF_V_LAST      = 511;
    localparam int unsigned DEF_HACT_START  = 256;
    localparam int unsigned DEF_HACT_END    = 511;
    localparam int unsigned DEF_HSYNC_START = 176;
    localparam int unsigned DEF_HSYNC_END   = 207;
    localparam int unsigned DEF_H_HALF      = 368;
    localparam int unsigned DEF_VACT_START  = 272;
    localparam int unsigned DEF_VACT_END    = 495;
    localparam int unsigned DEF_VSYNC_START = 248;
    localparam int unsigned DEF_VSYNC_END   = 255;

    function automatic logic in_span(input int unsigned val,
                                     input int unsigned lo,
                                     input int unsigned hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/k005292_span_dec.sv
// Inclusive range decoder: o_hit = LO <= i_val <= HI.
module k005292_span_dec
    import k005292_timing_pkg::*;
#(
    parameter int unsigned W  = 9,
    parameter int unsigned LO = 0,
    parameter int unsigned HI = 0
) (
    input  logic [W-1:0] i_val,
    output logic         o_hit
);

    always_comb o_hit = in_span(32'(i_val), LO, HI);

endmodule

// File: rtl/k005292_timing_gen.sv
// Parametrised video timing generator: counters, flips, blanks, syncs and field.
// Define K005292_TIMING_GEN_LINE_IRQ_EN to build the line-compare interrupt.
module k005292_timing_gen
    import k005292_timing_pkg::*;
#(
    parameter int unsigned HW          = DEF_HW,
    parameter int unsigned VW          = DEF_VW,
    parameter int unsigned H_FIRST     = DEF_H_FIRST,
    parameter int unsigned H_LAST      = DEF_H_LAST,
    parameter int unsigned V_FIRST     = DEF_V_FIRST,
    parameter int unsigned V_LAST      = DEF_V_LAST,
    parameter int unsigned HACT_START  = DEF_HACT_START,
    parameter int unsigned HACT_END    = DEF_HACT_END,
    parameter int unsigned HSYNC_START = DEF_HSYNC_START,
    parameter int unsigned HSYNC_END   = DEF_HSYNC_END,
    parameter int unsigned H_HALF      = DEF_H_HALF,
    parameter int unsigned VACT_START  = DEF_VACT_START,
    parameter int unsigned VACT_END    = DEF_VACT_END,
    parameter int unsigned VSYNC_START = DEF_VSYNC_START,
    parameter int unsigned VSYNC_END   = DEF_VSYNC_END
) (
    input  logic          i_EMU_MCLK,
    input  logic          i_MRST_n,
    input  logic          i_EMU_CLK6MPCEN_n,
    input  logic          i_HFLIP,
    input  logic          i_VFLIP,
    input  logic          i_INTER,
    input  logic [VW-1:0] i_LINE_CMP,
    output logic [HW-1:0] o_ABS_H,
    output logic [VW-1:0] o_ABS_V,
    output logic [HW-1:0] o_FLIP_H,
    output logic [VW-1:0] o_FLIP_V,
    output logic          o_HBLANK_n,
    output logic          o_VBLANK_n,
    output logic          o_HSYNC_n,
    output logic          o_VSYNC_n,
    output logic          o_CSYNC_n,
    output logic          o_VCLK,
    output logic          o_FIELD,
    output logic          o_LINE_IRQ
);

    if (H_FIRST >= H_LAST) begin : g_bad_h
        $error("k005292_timing_gen: H_FIRST must be below H_LAST");
    end
    if (V_FIRST >= V_LAST) begin : g_bad_v
        $error("k005292_timing_gen: V_FIRST must be below V_LAST");
    end

    logic [HW-1:0] hcntr_q, hcntr_d;
    logic [VW-1:0] vcntr_q, vcntr_d;
    logic          field_q, field_d;
    logic          vsync_q, vsync_d;

    logic          cen;
    logic          line_adv;
    logic          half_pt;
    logic          v_wrap;
    logic [VW-1:0] vcntr_nxt;
    logic [VW-1:0] vsync_src;
    logic          hact_hit, hsync_hit, vact_hit, vsync_hit;
    logic          hsync_n, vsync_n;

    always_comb begin
        cen       = ~i_EMU_CLK6MPCEN_n;
        line_adv  = (hcntr_q == HW'(HSYNC_START - 1));
        half_pt   = (hcntr_q == HW'(H_HALF - 1));
        v_wrap    = (vcntr_q == VW'(V_LAST));
        vcntr_nxt = v_wrap ? VW'(V_FIRST) : vcntr_q + VW'(1);
        // Even fields look ahead to the line about to start; odd fields sample
        // the current line half a line later to get the interlace offset.
        vsync_src = field_q ? vcntr_q : vcntr_nxt;
    end

    k005292_span_dec #(.W(HW), .LO(HACT_START), .HI(HACT_END)) u_hact (
        .i_val (hcntr_q),
        .o_hit (hact_hit)
    );

    k005292_span_dec #(.W(HW), .LO(HSYNC_START), .HI(HSYNC_END)) u_hsync (
        .i_val (hcntr_q),
        .o_hit (hsync_hit)
    );

    k005292_span_dec #(.W(VW), .LO(VACT_START), .HI(VACT_END)) u_vact (
        .i_val (vcntr_q),
        .o_hit (vact_hit)
    );

    k005292_span_dec #(.W(VW), .LO(VSYNC_START), .HI(VSYNC_END)) u_vsync (
        .i_val (vsync_src),
        .o_hit (vsync_hit)
    );

    always_comb begin
        hcntr_d = hcntr_q;
        vcntr_d = vcntr_q;
        field_d = field_q;
        vsync_d = vsync_q;
        if (cen) begin
            hcntr_d = (hcntr_q == HW'(H_LAST)) ? HW'(H_FIRST) : hcntr_q + HW'(1);
            if (line_adv) begin
                vcntr_d = vcntr_nxt;
                if (v_wrap) begin
                    field_d = i_INTER ? ~field_q : 1'b0;
                end
            end
            if (field_q ? half_pt : line_adv) begin
                vsync_d = vsync_hit;
            end
        end
    end

    always_ff @(posedge i_EMU_MCLK) begin
        if (!i_MRST_n) begin
            hcntr_q <= HW'(H_FIRST);
            vcntr_q <= VW'(V_FIRST);
            field_q <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            hcntr_q <= hcntr_d;
            vcntr_q <= vcntr_d;
            field_q <= field_d;
            vsync_q <= vsync_d;
        end
    end

`ifdef K005292_TIMING_GEN_LINE_IRQ_EN
    logic irq_q, irq_d;

    // Held across disabled master clocks so the pulse spans one pixel period.
    always_comb begin
        irq_d = irq_q;
        if (cen) begin
            irq_d = line_adv && (vcntr_nxt == i_LINE_CMP);
        end
    end

    always_ff @(posedge i_EMU_MCLK) begin
        if (!i_MRST_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign o_LINE_IRQ = irq_q;
`else
    logic unused_line_cmp;
    assign unused_line_cmp = ^i_LINE_CMP;
    assign o_LINE_IRQ      = 1'b0;
`endif

    always_comb begin
        hsync_n    = ~hsync_hit;
        vsync_n    = ~vsync_q;
        o_ABS_H    = hcntr_q;
        o_ABS_V    = vcntr_q;
        o_FLIP_H   = hcntr_q ^ {HW{i_HFLIP}};
        o_FLIP_V   = vcntr_q ^ {VW{i_VFLIP}};
        o_HBLANK_n = hact_hit;
        o_VBLANK_n = vact_hit;
        o_HSYNC_n  = hsync_n;
        o_VSYNC_n  = vsync_n;
        o_CSYNC_n  = ~(hsync_n ^ vsync_n);
        o_VCLK     = hsync_hit;
        o_FIELD    = field_q;
    end

endmodule
